// File: rtl/beidou_b1i_pkg.sv
// rtl/beidou_b1i_pkg.sv - shared constants, carrier table and state type for the B1I despreader
//
// Purpose: LFSR init values and feedback tap masks, default code length,
//          4-phase carrier lookup, tracking state enum and the LFSR step helper.
// Ports:   none (package).

package beidou_b1i_pkg;

   localparam int          CODE_LEN_DEF = 2046;

   localparam logic [10:0] G1_INIT = 11'b11010110101;
   localparam logic [10:0] G2_INIT = 11'b00001000101;

   // Feedback taps: G1 uses bits 10,9,8,7,6,0; G2 uses bits 10,9,8,7,4,3,2,1,0.
   localparam logic [10:0] G1_TAPS = 11'b11111000001;
   localparam logic [10:0] G2_TAPS = 11'b11110011111;

   typedef logic signed [1:0] carrier_t;

   // Carrier phase 0..3 -> +1, 0, -1, 0
   localparam carrier_t CARRIER_LUT [4] = '{2'sb01, 2'sb00, 2'sb11, 2'sb00};

   typedef enum logic {
      SEARCH = 1'b0,
      TRACK  = 1'b1
   } state_e;

   function automatic logic [10:0] lfsr_step(input logic [10:0] s, input logic [10:0] taps);
      return {s[9:0], ^(s & taps)};
   endfunction

endpackage

// File: rtl/beidou_b1i_codegen.sv
// rtl/beidou_b1i_codegen.sv - B1I G1^G2 ranging code generator with chip-slip support
//
// Purpose: runs the G1/G2 LFSRs at one chip per CHIP_CYCLES clocks, reloads them
//          at the end of each code period, and inserts one extra (dead) chip
//          period when a slip is requested so the local code falls back one chip.
// Ports:   clk, rst_n   - clock, asynchronous active-low reset
//          slip_req     - request a one-chip delay of the local code
//          code_bit     - current chip (1 -> +1, 0 -> -1)
//          chip_stb     - last clk of a real chip
//          epoch        - last clk of the last chip of a code period
//          in_slip      - high during the inserted extra chip period

module beidou_b1i_codegen
   import beidou_b1i_pkg::*;
#(
   parameter int CHIP_CYCLES = 3052,
   parameter int CODE_LEN    = CODE_LEN_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic slip_req,
   output logic code_bit,
   output logic chip_stb,
   output logic epoch,
   output logic in_slip
);

   localparam int CW = $clog2(CHIP_CYCLES);
   localparam int IW = $clog2(CODE_LEN);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [10:0]   g1_q, g1_d;
   logic [10:0]   g2_q, g2_d;
   logic          slip_q, slip_d;   // inside the inserted extra chip period
   logic          pend_q, pend_d;   // slip waiting for the next chip boundary
   logic          cnt_end;

   assign cnt_end  = (cnt_q == CW'(CHIP_CYCLES - 1));
   assign chip_stb = cnt_end & ~slip_q;
   assign epoch    = chip_stb & (idx_q == IW'(CODE_LEN - 1));
   assign in_slip  = slip_q;
   assign code_bit = g1_q[10] ^ g2_q[0] ^ g2_q[2];

   always_comb begin
      cnt_d  = cnt_end ? '0 : cnt_q + CW'(1);
      idx_d  = idx_q;
      g1_d   = g1_q;
      g2_d   = g2_q;
      slip_d = slip_q;
      pend_d = pend_q | slip_req;
      if (cnt_end) begin
         if (slip_q) begin
            // Extra period over; the held chip now plays normally.
            slip_d = 1'b0;
         end else begin
            if (idx_q == IW'(CODE_LEN - 1)) begin
               idx_d = '0;
               g1_d  = G1_INIT;
               g2_d  = G2_INIT;
            end else begin
               idx_d = idx_q + IW'(1);
               g1_d  = lfsr_step(g1_q, G1_TAPS);
               g2_d  = lfsr_step(g2_q, G2_TAPS);
            end
            // A request arriving on the boundary clk (e.g. with the epoch)
            // delays the very next chip.
            if (pend_q | slip_req) begin
               slip_d = 1'b1;
               pend_d = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         idx_q  <= '0;
         g1_q   <= G1_INIT;
         g2_q   <= G2_INIT;
         slip_q <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         idx_q  <= idx_d;
         g1_q   <= g1_d;
         g2_q   <= g2_d;
         slip_q <= slip_d;
         pend_q <= pend_d;
      end
   end

endmodule

// File: rtl/beidou_b1i_despreader.sv
// rtl/beidou_b1i_despreader.sv - B1I carrier wipe-off, despread, integrate-and-dump and lock FSM
//
// Purpose: multiplies IFin by a 4-phase carrier and the local ranging code,
//          integrates over INTEG_CODES code periods, dumps the sum, and runs a
//          SEARCH/TRACK machine that slips the code one chip per failed dump.
// Ports:   clk, rst_n  - clock, asynchronous active-low reset
//          IFin        - 2-bit signed IF sample (-2..+1), one per clk
//          corr_valid  - one-cycle pulse per dump
//          corr_val    - last dump value (signed ACC_W)
//          decode_D    - 1 when the last dump was >= 0
//          flag        - 1 while in TRACK

module beidou_b1i_despreader
   import beidou_b1i_pkg::*;
#(
   parameter int CHIP_CYCLES = 3052,
   parameter int CODE_LEN    = CODE_LEN_DEF,
   parameter int INTEG_CODES = 2,
   parameter int ACC_W       = 28,
   parameter int THRESH      = 3122196,
   parameter int LOCK_CNT    = 2,
   parameter int MISS_CNT    = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic signed [1:0]       IFin,
   output logic                    corr_valid,
   output logic signed [ACC_W-1:0] corr_val,
   output logic                    decode_D,
   output logic                    flag
);

   localparam int EW  = (INTEG_CODES > 1) ? $clog2(INTEG_CODES) : 1;
   localparam int CNW = $clog2(((LOCK_CNT > MISS_CNT) ? LOCK_CNT : MISS_CNT) + 1);

   logic [1:0]              phase_q, phase_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [EW-1:0]           ep_q, ep_d;
   state_e                  state_q, state_d;
   logic [CNW-1:0]          hit_q, hit_d;
   logic [CNW-1:0]          miss_q, miss_d;
   logic                    valid_q, valid_d;
   logic signed [ACC_W-1:0] corr_q, corr_d;
   logic                    dec_q, dec_d;

   logic                    code_bit, epoch, in_slip, slip_req;
   logic                    unused_chip_stb;
   carrier_t                carrier;
   logic signed [2:0]       if_ext, prod;
   logic signed [ACC_W-1:0] sum_w;
   logic [ACC_W-1:0]        abs_w;
   logic                    dump, hit;

   beidou_b1i_codegen #(
      .CHIP_CYCLES (CHIP_CYCLES),
      .CODE_LEN    (CODE_LEN)
   ) u_codegen (
      .clk      (clk),
      .rst_n    (rst_n),
      .slip_req (slip_req),
      .code_bit (code_bit),
      .chip_stb (unused_chip_stb),
      .epoch    (epoch),
      .in_slip  (in_slip)
   );

   always_comb begin
      phase_d = phase_q + 2'd1;
      carrier = CARRIER_LUT[phase_q];
      if_ext  = {IFin[1], IFin};
      // Sign flips when exactly one of carrier and code is negative.
      if (carrier == '0)
         prod = '0;
      else if (carrier[1] ^ ~code_bit)
         prod = -if_ext;
      else
         prod = if_ext;

      sum_w = acc_q + {{(ACC_W-3){prod[2]}}, prod};
      abs_w = sum_w[ACC_W-1] ? -sum_w : sum_w;
      hit   = (abs_w >= ACC_W'(THRESH));
      dump  = epoch & (ep_q == EW'(INTEG_CODES - 1));

      acc_d   = in_slip ? acc_q : sum_w;
      ep_d    = ep_q;
      valid_d = dump;
      corr_d  = corr_q;
      dec_d   = dec_q;
      if (epoch)
         ep_d = dump ? '0 : ep_q + EW'(1);
      if (dump) begin
         corr_d = sum_w;
         dec_d  = ~sum_w[ACC_W-1];
         acc_d  = '0;
      end

      state_d  = state_q;
      hit_d    = hit_q;
      miss_d   = miss_q;
      slip_req = 1'b0;
      if (dump) begin
         case (state_q)
            SEARCH: begin
               if (hit) begin
                  if (hit_q == CNW'(LOCK_CNT - 1)) begin
                     state_d = TRACK;
                     hit_d   = '0;
                     miss_d  = '0;
                  end else begin
                     hit_d = hit_q + CNW'(1);
                  end
               end else begin
                  hit_d    = '0;
                  slip_req = 1'b1;
               end
            end
            TRACK: begin
               if (!hit) begin
                  if (miss_q == CNW'(MISS_CNT - 1)) begin
                     state_d = SEARCH;
                     hit_d   = '0;
                     miss_d  = '0;
                  end else begin
                     miss_d = miss_q + CNW'(1);
                  end
               end else begin
                  miss_d = '0;
               end
            end
            default: state_d = SEARCH;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= '0;
         acc_q   <= '0;
         ep_q    <= '0;
         state_q <= SEARCH;
         hit_q   <= '0;
         miss_q  <= '0;
         valid_q <= 1'b0;
         corr_q  <= '0;
         dec_q   <= 1'b0;
      end else begin
         phase_q <= phase_d;
         acc_q   <= acc_d;
         ep_q    <= ep_d;
         state_q <= state_d;
         hit_q   <= hit_d;
         miss_q  <= miss_d;
         valid_q <= valid_d;
         corr_q  <= corr_d;
         dec_q   <= dec_d;
      end
   end

   assign corr_valid = valid_q;
   assign corr_val   = corr_q;
   assign decode_D   = dec_q;
   assign flag       = (state_q == TRACK);

endmodule

// File: tb/tb_beidou_b1i_despreader.sv
// tb/tb_beidou_b1i_despreader.sv - directed self-checking bench for beidou_b1i_despreader

module tb_beidou_b1i_despreader;

   localparam int CC    = 4;
   localparam int CL    = 2046;
   localparam int WIN   = CC * CL;
   localparam int ACC_W = 28;
   localparam int THR   = 2046;
   localparam int PEAK  = 4092;
   localparam int NEVER = 1 << 30;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b1;
   logic signed [1:0]       IFin = '0;
   logic                    corr_valid;
   logic signed [ACC_W-1:0] corr_val;
   logic                    decode_D;
   logic                    flag;

   always #5 clk = ~clk;

   beidou_b1i_despreader #(
      .CHIP_CYCLES (CC),
      .CODE_LEN    (CL),
      .INTEG_CODES (1),
      .ACC_W       (ACC_W),
      .THRESH      (THR),
      .LOCK_CNT    (2),
      .MISS_CNT    (3)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .IFin       (IFin),
      .corr_valid (corr_valid),
      .corr_val   (corr_val),
      .decode_D   (decode_D),
      .flag       (flag)
   );

   int n_tests = 0;
   int n_fail  = 0;
   bit code_ref [CL];
   int k;        // samples processed since last reset release
   int dly;      // incoming code delay in clk
   int flip_k;   // first sample with data bit 0
   int zero_k;   // first sample driven as 0
   int n_valid;

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic signed [1:0] if_of(input int kk);
      int j, car, c, ds;
      if (kk >= zero_k) return 2'sb00;
      j = kk - dly;
      if (j < 0) j += WIN;
      j = j % WIN;
      c = code_ref[j / CC] ? 1 : -1;
      case (kk % 4)
         0:       car = 1;
         2:       car = -1;
         default: car = 0;
      endcase
      ds = (kk >= flip_k) ? -1 : 1;
      return 2'(ds * car * c);
   endfunction

   task automatic run_to(input int target);
      while (k < target) begin
         @(posedge clk);
         #1;
         k++;
         if (corr_valid) n_valid++;
         IFin = if_of(k);
      end
   endtask

   task automatic check_abs_below(input string tag);
      int v;
      v = corr_val;
      if (v < 0) v = -v;
      check(tag, (v < THR) ? 1 : 0, 1);
   endtask

   initial begin
      logic [10:0] g1, g2;
      g1 = 11'b11010110101;
      g2 = 11'b00001000101;
      for (int i = 0; i < CL; i++) begin
         code_ref[i] = g1[10] ^ g2[0] ^ g2[2];
         g1 = {g1[9:0], g1[10] ^ g1[9] ^ g1[8] ^ g1[7] ^ g1[6] ^ g1[0]};
         g2 = {g2[9:0], g2[10] ^ g2[9] ^ g2[8] ^ g2[7] ^ g2[4] ^ g2[3] ^ g2[2] ^ g2[1] ^ g2[0]};
      end
      dly = 0; flip_k = NEVER; zero_k = NEVER; k = 0; n_valid = 0;

      // Reset held with random input
      #2 rst_n = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         IFin = 2'($urandom_range(0, 3));
         check("rst_flag", flag, 0);
         check("rst_decode", decode_D, 0);
         check("rst_valid", corr_valid, 0);
         check("rst_corr", corr_val, 0);
      end
      rst_n = 1'b1;
      k = 0;
      IFin = if_of(0);

      // Aligned, D=1: first dump at clk WIN, lock after the second
      run_to(WIN - 1);
      check("d1_no_early_valid", n_valid, 0);
      check("d1_valid_low_before", corr_valid, 0);
      run_to(WIN);
      check("d1_valid", corr_valid, 1);
      check("d1_corr", corr_val, PEAK);
      check("d1_decode", decode_D, 1);
      check("d1_flag", flag, 0);
      run_to(WIN + 1);
      check("d1_pulse_one_cycle", corr_valid, 0);
      flip_k = 2 * WIN;
      run_to(2 * WIN);
      check("d2_valid", corr_valid, 1);
      check("d2_corr", corr_val, PEAK);
      check("d2_flag_locked", flag, 1);
      check("d2_count", n_valid, 2);

      // Data bit flips to 0 while tracking
      zero_k = 3 * WIN;
      run_to(3 * WIN);
      check("d3_valid", corr_valid, 1);
      check("d3_corr", corr_val, -PEAK);
      check("d3_decode", decode_D, 0);
      check("d3_flag", flag, 1);

      // Zero input in TRACK: three misses drop the lock
      run_to(4 * WIN);
      check("z1_corr", corr_val, 0);
      check("z1_decode_zero_is_one", decode_D, 1);
      check("z1_flag", flag, 1);
      run_to(5 * WIN);
      check("z2_flag", flag, 1);
      run_to(6 * WIN);
      check("z3_valid", corr_valid, 1);
      check("z3_corr", corr_val, 0);
      check("z3_flag_dropped", flag, 0);
      check("z3_count", n_valid, 6);

      // Reset pulse mid-window
      dly = 0; flip_k = NEVER; zero_k = NEVER;
      run_to(6 * WIN + 5000);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", corr_valid, 0);
      check("mid_rst_corr", corr_val, 0);
      check("mid_rst_decode", decode_D, 0);
      check("mid_rst_flag", flag, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      k = 0; n_valid = 0; dly = 3 * CC;
      IFin = if_of(0);

      // Incoming code 3 chips late: three slips then lock
      run_to(WIN - 1);
      check("slip_no_stale_dump", n_valid, 0);
      run_to(WIN);
      check("s1_valid", corr_valid, 1);
      check_abs_below("s1_below");
      check("s1_flag", flag, 0);
      run_to(2 * WIN + 4);
      check("s2_valid", corr_valid, 1);
      check_abs_below("s2_below");
      run_to(3 * WIN + 8);
      check("s3_valid", corr_valid, 1);
      check_abs_below("s3_below");
      check("s3_flag", flag, 0);
      run_to(4 * WIN + 12);
      check("s4_valid", corr_valid, 1);
      check("s4_corr", corr_val, PEAK);
      check("s4_flag", flag, 0);
      run_to(5 * WIN + 12);
      check("s5_valid", corr_valid, 1);
      check("s5_corr", corr_val, PEAK);
      check("s5_flag_locked", flag, 1);
      check("s5_count", n_valid, 5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/beidou_b1i_despreader.md
Name: beidou_b1i_despreader

Overview:
- Downstream consumer of the B1I IF sample stream `IFin` (2-bit signed, one sample per clk).
- Wipes off the carrier with a local 4-phase carrier (+1, 0, −1, 0) and despreads with a locally generated G1⊕G2 ranging code.
- Integrates over one data-bit window, then searches for code phase by chip slipping.
- Reports the decoded navigation bit and a lock flag to the top level.

Parameters:
- CHIP_CYCLES, 3052: clk cycles per code chip.
- CODE_LEN, 2046: chips per code period; both LFSRs reload at the wrap.
- INTEG_CODES, 2: code periods per integration (dump) window, i.e. one D bit.
- ACC_W, 28: accumulator / corr_val width (signed).
- THRESH, 3122196: |corr| lock threshold, half of the ideal peak.
- LOCK_CNT, 2: consecutive hits needed to enter TRACK.
- MISS_CNT, 3: consecutive misses needed to drop back to SEARCH.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous, active-low reset.
- IFin, in, 2 signed: IF sample, range −2..+1.
- corr_valid, out, 1: one-cycle pulse per dump.
- corr_val, out, ACC_W signed: last dump value.
- decode_D, out, 1: sign decision of the last dump (1 if corr_val ≥ 0).
- flag, out, 1: 1 while the state machine is in TRACK.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset: all outputs 0. Carrier phase = 0. LFSRs at their init values. Chip counter, chip index, epoch count and accumulator all 0. State = SEARCH.
- Carrier: phase counter p advances every clk (wraps 3→0). Carrier value: p=0 → +1, p=1 → 0, p=2 → −1, p=3 → 0.
- Code generator:
  - G1 init 11'b11010110101. Shift {g1[9:0], g1[10]^g1[9]^g1[8]^g1[7]^g1[6]^g1[0]}.
  - G2 init 11'b00001000101. Shift {g2[9:0], g2[10]^g2[9]^g2[8]^g2[7]^g2[4]^g2[3]^g2[2]^g2[1]^g2[0]}.
  - Chip bit = g1[10]^g2[0]^g2[2]. Bit 1 maps to +1, bit 0 maps to −1.
  - LFSRs step when the chip counter reaches CHIP_CYCLES−1.
  - At chip index CODE_LEN−1 the LFSRs reload their init values and the index wraps to 0; an epoch pulse is issued.
- Product = IFin × carrier × code sign, range −2..+2. Add it to the accumulator every clk except during a slip chip. No saturation is required at the chosen widths.
- Dump: on the clk of the INTEG_CODES-th epoch:
  - corr_val <= acc + product.
  - corr_valid = 1 for one cycle.
  - decode_D <= ~sign(acc + product).
  - acc <= 0.
  - Latency from the last sample of the window to corr_valid is 1 clk.
- FSM, evaluated on each dump:
  - SEARCH: if |corr| ≥ THRESH, increment the hit count; at LOCK_CNT go to TRACK (flag=1). Otherwise clear the hit count and request a slip.
  - Slip: the next chip lasts 2×CHIP_CYCLES (the local code is delayed one chip). Accumulation is inhibited and acc is held at 0 during the extra CHIP_CYCLES. The window boundary follows the epochs.
  - TRACK: |corr| < THRESH increments the miss count; at MISS_CNT go to SEARCH (flag=0) and clear both counts. A hit clears the miss count.
- Boundaries:
  - Slip requested at the same time as an epoch: the slip applies to chip 0 of the new period.
  - |corr| exactly equal to THRESH counts as a hit.
  - corr_val = 0 gives decode_D = 1.
  - Reset asserted mid-window: immediate clear of all state; the partial window is discarded and no corr_valid is issued.

Decomposition:
- Package beidou_b1i_pkg holds:
  - G1_INIT, G2_INIT, G1_TAPS, G2_TAPS, the default CODE_LEN.
  - The carrier LUT (4 × 2-bit signed).
  - The state enum {SEARCH, TRACK}.
- One sub-module, beidou_b1i_codegen:
  - Contains the LFSRs, chip counter, chip index and slip handling.
  - Outputs code_bit, chip_stb, epoch, in_slip.
- The top of this block holds the carrier counter, multiplier, accumulator, dump logic and FSM.

Test Plan (override parameters: CHIP_CYCLES=4, INTEG_CODES=1, THRESH=2046, LOCK_CNT=2, MISS_CNT=3; window = 8184 clk, ideal peak 4092):
1. Hold rst_n=0 with random IFin → flag=0, decode_D=0, corr_valid=0, corr_val=0 throughout.
2. IFin = carrier×(+code), D=1, phase-aligned from reset → corr_valid at clk 8184 with corr_val=+4092 and decode_D=1; flag rises after the 2nd dump.
3. Same as 2, then D flips to 0 (IFin = −carrier×code) at a window boundary while in TRACK → corr_val=−4092, decode_D=0, flag stays 1.
4. IFin delayed 3 chips (12 clk) relative to the local code → 3 failing dumps with 3 slips, then 2 dumps at |corr|=4092 → flag=1.
5. In TRACK, drive IFin=0 → corr_val=0 for 3 dumps, then flag falls to 0 and the state returns to SEARCH.
6. Pulse rst_n low for 1 clk mid-window (clk 5000) → outputs clear immediately, no corr_valid at clk 8184, next dump at 8184 clk after reset release.
